// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths for the shift-add multiplier datapath and its sequencer
package mult_pkg;
    localparam int N     = 8;
    localparam int REG_W = 2 * N + 1;
    localparam int CNT_W = $clog2(N + 1);
endpackage

// File: rtl/mult_datapath_if.sv
// rtl/mult_datapath_if.sv - control/status bundle between sequencer (master) and datapath (slave)
//   multiplicand, multiplier : operands, sampled on RESET
//   ADD, SHIFT, RESET, DECREMENT : control strobes from the sequencer
//   register : {C, A, Q}, count : remaining iterations, product : {A, Q}
interface mult_datapath_if;
    import mult_pkg::*;

    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic             ADD;
    logic             SHIFT;
    logic             RESET;
    logic             DECREMENT;
    logic [REG_W-1:0] register;
    logic [CNT_W-1:0] count;
    logic [2*N-1:0]   product;

    modport master (
        output multiplicand, multiplier, ADD, SHIFT, RESET, DECREMENT,
        input  register, count, product
    );

    modport slave (
        input  multiplicand, multiplier, ADD, SHIFT, RESET, DECREMENT,
        output register, count, product
    );
endinterface

// File: rtl/mult_add_shift.sv
// rtl/mult_add_shift.sv - combinational add-then-shift step producing the next {C, A, Q}
//   i_m : multiplicand M, i_c/i_a/i_q : current carry, accumulator, multiplier
//   i_add : add M into A, i_shift : shift {C, A, Q} right by one
//   o_next : next {C, A, Q}
module mult_add_shift
    import mult_pkg::*;
(
    input  logic [N-1:0]     i_m,
    input  logic             i_c,
    input  logic [N-1:0]     i_a,
    input  logic [N-1:0]     i_q,
    input  logic             i_add,
    input  logic             i_shift,
    output logic [REG_W-1:0] o_next
);
    logic [N:0] w_ca;

    // The add overwrites C with the carry out; the old C is not part of the sum.
    assign w_ca = i_add ? ({1'b0, i_a} + {1'b0, i_m}) : {i_c, i_a};

    // Shift happens after the add, so the fresh carry moves into A[N-1].
    assign o_next = i_shift ? {1'b0, w_ca, i_q[N-1:1]} : {w_ca, i_q};
endmodule

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - register side of the unsigned shift-add multiplier
//   clk   : rising-edge clock
//   reset : synchronous active-high clear of all state
//   bus   : slave side of mult_datapath_if (operands, strobes, register/count/product)
module mult_datapath
    import mult_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    mult_datapath_if.slave bus
);
    logic [REG_W-1:0] r_register;
    logic [CNT_W-1:0] r_count;
    logic [N-1:0]     r_m;
    logic [REG_W-1:0] w_next;

    mult_add_shift u_add_shift (
        .i_m     (r_m),
        .i_c     (r_register[REG_W-1]),
        .i_a     (r_register[2*N-1:N]),
        .i_q     (r_register[N-1:0]),
        .i_add   (bus.ADD),
        .i_shift (bus.SHIFT),
        .o_next  (w_next)
    );

    // Priority: reset, then operand load, then the datapath ops and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_register <= '0;
            r_count    <= '0;
            r_m        <= '0;
        end else if (bus.RESET) begin
            r_m        <= bus.multiplicand;
            r_register <= {1'b0, {N{1'b0}}, bus.multiplier};
            r_count    <= CNT_W'(N);
        end else begin
            r_register <= w_next;
            // Saturate at zero so a late DECREMENT cannot wrap the count.
            if (bus.DECREMENT && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign bus.register = r_register;
    assign bus.count    = r_count;
    assign bus.product  = r_register[2*N-1:0];
endmodule
